lif_threshold_reset_unit: RTL and testbench

- Parametrised, registered successor to the combinational membrane-voltage threshold/select stage of the digital neuron datapath.
- Serves N_CH time-multiplexed neuron channels. For each sample it compares the fixed-point membrane voltage against a programmable threshold and emits a spike.
- On a spike it substitutes the reset voltage and holds the channel in a per-channel refractory period.
- Sits between the membrane integrator and the synapse/spike-routing logic.

---
 rtl/lif_threshold_reset_unit.sv | 105 ++++++++++
 tb/tb_lif_threshold_reset_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_threshold_reset_unit.sv
// Registered threshold/reset stage for N_CH time-multiplexed LIF neuron channels:
// compares membrane voltage to a programmable threshold, emits spikes, and applies per-channel refractory holds.
module lif_threshold_reset_unit #(
  parameter int WIDTH = 21,
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH),
  parameter int REF_W = 4,
  parameter int CNT_W = 16,
  parameter logic signed [WIDTH-1:0] THR_INIT = 21'sd15360
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             thr_we,
  input  logic [WIDTH-1:0] thr_in,
  input  logic [REF_W-1:0] ref_cycles,
  input  logic [WIDTH-1:0] v_reset,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] v_in,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] v_out,
  output logic             spike,
  output logic             refractory,
  output logic [CNT_W-1:0] spike_total
);

  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [WIDTH-1:0] v_out_q;
  logic             spike_q;
  logic             refractory_q;
  logic [CNT_W-1:0] spike_total_q;
  logic [WIDTH-1:0] thr_q;
  logic [REF_W-1:0] ref_cnt_q [N_CH];

  logic             accept_c;
  logic [REF_W-1:0] cur_cnt_c;
  logic [WIDTH:0]   diff_c;
  logic             is_ref_c;
  logic             is_spike_c;

  // Difference is formed one bit wider so its sign bit is always the true sign of v_in - threshold.
  always_comb begin
    accept_c  = in_valid && ({1'b0, in_ch} < N_CH_L);
    cur_cnt_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ch == CH_W'(i)) cur_cnt_c = ref_cnt_q[i];
    end
    diff_c     = {v_in[WIDTH-1], v_in} - {thr_q[WIDTH-1], thr_q};
    is_ref_c   = (cur_cnt_c != '0);
    is_spike_c = !is_ref_c && !v_in[WIDTH-1] && !diff_c[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      v_out_q       <= '0;
      spike_q       <= 1'b0;
      refractory_q  <= 1'b0;
      spike_total_q <= '0;
      thr_q         <= THR_INIT;
      for (int i = 0; i < N_CH; i++) ref_cnt_q[i] <= '0;
    end else begin
      if (thr_we) thr_q <= thr_in;
      out_valid_q <= accept_c;
      if (accept_c) begin
        out_ch_q <= in_ch;
        if (is_ref_c) begin
          v_out_q      <= v_reset;
          spike_q      <= 1'b0;
          refractory_q <= 1'b1;
        end else if (is_spike_c) begin
          v_out_q      <= v_reset;
          spike_q      <= 1'b1;
          refractory_q <= 1'b0;
        end else begin
          v_out_q      <= v_in;
          spike_q      <= 1'b0;
          refractory_q <= 1'b0;
        end
        if (is_spike_c && (spike_total_q != {CNT_W{1'b1}}))
          spike_total_q <= spike_total_q + CNT_W'(1);
        // Only the sampled channel's counter moves; others wait for their own samples.
        for (int i = 0; i < N_CH; i++) begin
          if (in_ch == CH_W'(i)) begin
            if (is_ref_c) ref_cnt_q[i] <= cur_cnt_c - REF_W'(1);
            else if (is_spike_c) ref_cnt_q[i] <= ref_cycles;
          end
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign v_out       = v_out_q;
  assign spike       = spike_q;
  assign refractory  = refractory_q;
  assign spike_total = spike_total_q;

endmodule

// File: tb/tb_lif_threshold_reset_unit.sv
// Bench for lif_threshold_reset_unit: a behavioural model fills an expected queue at drive time,
// a monitor pops and compares on each out_valid; a second instance covers channel drop and counter saturation.
module tb_lif_threshold_reset_unit;

  localparam int W   = 21;
  localparam int EW  = 2 + W + 1 + 1 + 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          thr_we = 1'b0;
  logic [W-1:0]  thr_in = '0;
  logic [3:0]    ref_cycles = '0;
  logic [W-1:0]  v_reset = 21'(-2048);
  logic          in_valid = 1'b0;
  logic [1:0]    in_ch = '0;
  logic [W-1:0]  v_in = '0;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [W-1:0]  v_out;
  logic          spike;
  logic          refractory;
  logic [15:0]   spike_total;

  // Second instance: wider channel index so out-of-range channels are representable, 4-bit counter.
  logic          s_thr_we = 1'b0;
  logic          s_in_valid = 1'b0;
  logic [2:0]    s_in_ch = '0;
  logic [W-1:0]  s_v_in = '0;
  logic          s_out_valid;
  logic [2:0]    s_out_ch;
  logic [W-1:0]  s_v_out;
  logic          s_spike;
  logic          s_refractory;
  logic [3:0]    s_spike_total;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_t[$];

  int m_thr;
  int m_ref [4];
  int m_total;

  lif_threshold_reset_unit dut (
    .clk(clk), .rst(rst), .thr_we(thr_we), .thr_in(thr_in), .ref_cycles(ref_cycles),
    .v_reset(v_reset), .in_valid(in_valid), .in_ch(in_ch), .v_in(v_in),
    .out_valid(out_valid), .out_ch(out_ch), .v_out(v_out), .spike(spike),
    .refractory(refractory), .spike_total(spike_total)
  );

  lif_threshold_reset_unit #(.N_CH(4), .CH_W(3), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .thr_we(s_thr_we), .thr_in(thr_in), .ref_cycles(ref_cycles),
    .v_reset(v_reset), .in_valid(s_in_valid), .in_ch(s_in_ch), .v_in(s_v_in),
    .out_valid(s_out_valid), .out_ch(s_out_ch), .v_out(s_v_out), .spike(s_spike),
    .refractory(s_refractory), .spike_total(s_spike_total)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int t;
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got ch=%0d v=%0d spike=%0b refr=%0b total=%0d, required no output",
                 out_ch, $signed(v_out), spike, refractory, spike_total);
      end else begin
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        if ({out_ch, v_out, spike, refractory, spike_total} !== e || cyc != t) begin
          errors++;
          $display("FAIL sample_out: got ch=%0d v=%0d spike=%0b refr=%0b total=%0d cyc=%0d, required ch=%0d v=%0d spike=%0b refr=%0b total=%0d cyc=%0d",
                   out_ch, $signed(v_out), spike, refractory, spike_total, cyc,
                   e[EW-1 -: 2], $signed(e[EW-3 -: W]), e[17], e[16], e[15:0], t);
        end
      end
    end
  end

  task automatic model_reset();
    m_thr = 15360;
    m_total = 0;
    for (int i = 0; i < 4; i++) m_ref[i] = 0;
  endtask

  // driver: one sample per call, model evaluated against pre-edge state
  task automatic send(input int ch, input int v, input bit we = 1'b0, input int thr = 0,
                      input int rc = -1);
    bit sp, rf;
    int vo;
    @(negedge clk);
    if (rc >= 0) ref_cycles = 4'(rc);
    if (m_ref[ch] > 0) begin
      rf = 1'b1; sp = 1'b0; vo = $signed(v_reset); m_ref[ch]--;
    end else if (v >= 0 && v >= m_thr) begin
      rf = 1'b0; sp = 1'b1; vo = $signed(v_reset); m_ref[ch] = int'(ref_cycles);
      if (m_total < 65535) m_total++;
    end else begin
      rf = 1'b0; sp = 1'b0; vo = v;
    end
    exp_q.push_back({2'(ch), W'(vo), sp, rf, 16'(m_total)});
    exp_t.push_back(cyc + 1);
    in_valid = 1'b1;
    in_ch = 2'(ch);
    v_in = W'(v);
    thr_we = we;
    thr_in = W'(thr);
    if (we) m_thr = thr;
  endtask

  task automatic write_thr(input int thr);
    @(negedge clk);
    in_valid = 1'b0;
    thr_we = 1'b1;
    thr_in = W'(thr);
    m_thr = thr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      thr_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_ch, v_out, spike, refractory, spike_total} !== '0) begin
      errors++;
      $display("FAIL reset_main: got valid=%0b ch=%0d v=%0d spike=%0b refr=%0b total=%0d, required all 0",
               out_valid, out_ch, $signed(v_out), spike, refractory, spike_total);
    end
    checks++;
    if ({s_out_valid, s_out_ch, s_v_out, s_spike, s_refractory, s_spike_total} !== '0) begin
      errors++;
      $display("FAIL reset_small: got valid=%0b total=%0d, required all 0", s_out_valid, s_spike_total);
    end
    rst = 1'b0;
  endtask

  task automatic test_threshold();
    send(0, 15359);
    send(0, 15360);
    send(3, 15361);
    send(2, 1048575);
    send(1, 0);
    idle(2);
  endtask

  task automatic test_negative();
    write_thr(0);
    send(0, -100000);
    send(1, 0);
    send(2, -1);
    send(3, -1048576);
    write_thr(-500);
    send(0, -100);
    send(1, 0);
    write_thr(15360);
    idle(2);
  endtask

  task automatic test_refractory();
    send(1, 20000, 1'b0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      send(0, 20000);
      send(1, 20000);
    end
    idle(3);
    send(1, 20000, 1'b0, 0, 0);
    send(1, 20000);
    send(1, 20000, 1'b0, 0, 7);
    send(1, 20000);
    send(1, 20000);
    send(0, 20000, 1'b0, 0, 0);
    send(0, 20000);
    send(0, 20000);
    idle(2);
  endtask

  task automatic test_thr_same_cycle();
    send(2, 5000, 1'b1, 1000);
    send(2, 5000);
    send(3, 999);
    send(3, 1000);
    write_thr(15360);
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int v, rc, thr;
      bit we;
      v   = int'($urandom_range(0, 60000)) - 30000;
      rc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      we  = ($urandom_range(0, 7) == 0);
      thr = int'($urandom_range(0, 25000));
      send(int'($urandom_range(0, 3)), v, we, thr, rc);
    end
    idle(3);
  endtask

  task automatic test_drop_saturate();
    @(negedge clk);
    ref_cycles = '0;
    s_in_valid = 1'b1;
    s_in_ch = 3'd5;
    s_v_in = W'(20000);
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_spike_total !== 4'd0) begin
      errors++;
      $display("FAIL drop_ch5: got valid=%0b total=%0d, required valid=0 total=0", s_out_valid, s_spike_total);
    end
    s_in_valid = 1'b1;
    s_in_ch = 3'd0;
    for (int k = 1; k <= 20; k++) begin
      s_in_ch = 3'(k % 4);
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b1 || s_spike !== 1'b1 || s_spike_total !== 4'(k > 15 ? 15 : k)) begin
        errors++;
        $display("FAIL saturate_%0d: got valid=%0b spike=%0b total=%0d, required valid=1 spike=1 total=%0d",
                 k, s_out_valid, s_spike, s_spike_total, (k > 15 ? 15 : k));
      end
    end
    s_in_ch = 3'd7;
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_spike_total !== 4'd15) begin
      errors++;
      $display("FAIL drop_ch7: got valid=%0b total=%0d, required valid=0 total=15", s_out_valid, s_spike_total);
    end
  endtask

  task automatic test_reset_midflight();
    send(0, 20000, 1'b0, 0, 3);
    idle(2);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch = 2'd0;
    v_in = W'(100);
    #2 rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || spike_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_midflight: got valid=%0b total=%0d, required valid=0 total=0", out_valid, spike_total);
    end
    model_reset();
    exp_q.delete();
    exp_t.delete();
    rst = 1'b0;
    idle(1);
    send(0, 20000);
    send(0, 20000);
    idle(3);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_threshold();
    test_negative();
    test_refractory();
    test_thr_same_cycle();
    test_back_to_back();
    test_drop_saturate();
    test_reset_midflight();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
